// File: rtl/mem_stage_dmem_if_pkg.sv
// Shared definitions for the MEM stage data-memory interface.
package mem_stage_dmem_if_pkg;

    localparam int INTERNAL_BITS = 32;

    // M control field bit positions: {branch, mem_read, mem_write}
    localparam int M_BRANCH = 2;
    localparam int M_READ   = 1;
    localparam int M_WRITE  = 0;

    // WB control field bit positions: {reg_write, mem_to_reg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } dmem_state_t;

endpackage

// File: rtl/mem_stage_dmem_if_mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the WB control field and holds
// the remaining fields, so no register write can occur from a bubble.
import mem_stage_dmem_if_pkg::*;

module mem_wb_reg (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bubble,
    input  logic [1:0]               wb_in,
    input  logic [INTERNAL_BITS-1:0] rdata_in,
    input  logic [INTERNAL_BITS-1:0] alu_in,
    input  logic [4:0]               dst_in,
    output logic [1:0]               wb_out,
    output logic [INTERNAL_BITS-1:0] rdata_out,
    output logic [INTERNAL_BITS-1:0] alu_out,
    output logic [4:0]               dst_out
);

    // Load stage values, or insert a bubble that only kills the WB control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_out    <= 2'b00;
            rdata_out <= {INTERNAL_BITS{1'b0}};
            alu_out   <= {INTERNAL_BITS{1'b0}};
            dst_out   <= 5'd0;
        end else if (bubble) begin
            wb_out    <= 2'b00;
        end else begin
            wb_out    <= wb_in;
            rdata_out <= rdata_in;
            alu_out   <= alu_in;
            dst_out   <= dst_in;
        end
    end

endmodule

// File: rtl/mem_stage_dmem_if.sv
// MEM stage: decodes the M field, runs load/store accesses over a req/ack
// handshake, stalls the front of the pipe while an access is outstanding and
// resolves the branch decision.
// Optional build macro DMEM_MISALIGN_CHK_EN: misaligned accesses are dropped
// and flagged on a sticky misalign_err.
import mem_stage_dmem_if_pkg::*;

module mem_stage_dmem_if (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               WB_in,
    input  logic [2:0]               M_in,
    input  logic [INTERNAL_BITS-1:0] ALU_result_in,
    input  logic [INTERNAL_BITS-1:0] ALU_src2_in,
    input  logic                     ALU_zero_in,
    input  logic [INTERNAL_BITS-1:0] PC_in,
    input  logic [4:0]               REG_dst_in,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [INTERNAL_BITS-1:0] dmem_addr,
    output logic [INTERNAL_BITS-1:0] dmem_wdata,
    input  logic                     dmem_ack,
    input  logic [INTERNAL_BITS-1:0] dmem_rdata,
    output logic                     stall,
    output logic                     pc_src,
    output logic [INTERNAL_BITS-1:0] branch_target,
    output logic [1:0]               WB_out,
    output logic [INTERNAL_BITS-1:0] mem_rdata_out,
    output logic [INTERNAL_BITS-1:0] ALU_result_out,
    output logic [4:0]               REG_dst_out,
    output logic                     misalign_err
);

    dmem_state_t              state_r;
    logic                     acc_s;
    logic                     misalign_s;
    logic                     start_s;
    logic                     stall_s;
    logic                     bubble_s;
    logic [INTERNAL_BITS-1:0] rdata_sel_s;

    assign acc_s = M_in[M_READ] | M_in[M_WRITE];

`ifdef DMEM_MISALIGN_CHK_EN
    assign misalign_s = acc_s & (ALU_result_in[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    // A new access is launched only from IDLE and only if it is allowed.
    assign start_s = (state_r == S_IDLE) & acc_s & ~misalign_s;

    // Branches never touch memory, so the decision is independent of stall.
    assign pc_src        = M_in[M_BRANCH] & ALU_zero_in;
    assign branch_target = PC_in;
    assign stall         = stall_s;

    // Stall, bubble and load-data selection for the current state.
    always_comb begin
        stall_s     = 1'b0;
        bubble_s    = 1'b0;
        rdata_sel_s = {INTERNAL_BITS{1'b0}};
        case (state_r)
            S_IDLE: begin
                if (acc_s) begin
                    stall_s  = ~misalign_s;
                    bubble_s = 1'b1;
                end else begin
                    stall_s  = 1'b0;
                    bubble_s = 1'b0;
                end
            end
            S_BUSY: begin
                stall_s  = ~dmem_ack;
                bubble_s = ~dmem_ack;
                if (dmem_we) begin
                    rdata_sel_s = {INTERNAL_BITS{1'b0}};
                end else begin
                    rdata_sel_s = dmem_rdata;
                end
            end
            default: begin
                stall_s     = 1'b0;
                bubble_s    = 1'b1;
                rdata_sel_s = {INTERNAL_BITS{1'b0}};
            end
        endcase
    end

    // Access FSM with the request registers; fields are frozen while BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= {INTERNAL_BITS{1'b0}};
            dmem_wdata <= {INTERNAL_BITS{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        state_r    <= S_BUSY;
                        dmem_req   <= 1'b1;
                        dmem_we    <= M_in[M_WRITE];
                        dmem_addr  <= ALU_result_in;
                        dmem_wdata <= ALU_src2_in;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (dmem_ack) begin
                        state_r  <= S_IDLE;
                        dmem_req <= 1'b0;
                    end else begin
                        state_r  <= S_BUSY;
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_MISALIGN_CHK_EN
    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if ((state_r == S_IDLE) && misalign_s) begin
            misalign_err <= 1'b1;
        end else begin
            misalign_err <= misalign_err;
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

    mem_wb_reg u_mem_wb_reg (
        .clk       (clk),
        .rst       (rst),
        .bubble    (bubble_s),
        .wb_in     (WB_in),
        .rdata_in  (rdata_sel_s),
        .alu_in    (ALU_result_in),
        .dst_in    (REG_dst_in),
        .wb_out    (WB_out),
        .rdata_out (mem_rdata_out),
        .alu_out   (ALU_result_out),
        .dst_out   (REG_dst_out)
    );

endmodule

// File: tb/tb_mem_stage_dmem_if.sv
// Directed bench for mem_stage_dmem_if; inputs change 1 time unit after the
// rising edge and outputs are sampled before the next rising edge.
module tb_mem_stage_dmem_if;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  WB_in = 2'b00;
    logic [2:0]  M_in = 3'b000;
    logic [31:0] ALU_result_in = 32'd0;
    logic [31:0] ALU_src2_in = 32'd0;
    logic        ALU_zero_in = 1'b0;
    logic [31:0] PC_in = 32'd0;
    logic [4:0]  REG_dst_in = 5'd0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_req, dmem_we, stall, pc_src, misalign_err;
    logic [31:0] dmem_addr, dmem_wdata, branch_target, mem_rdata_out, ALU_result_out;
    logic [1:0]  WB_out;
    logic [4:0]  REG_dst_out;

    int checks = 0;
    int failures = 0;
    int stall_cnt;
    int req_cnt;

    mem_stage_dmem_if dut (
        .clk(clk), .rst(rst), .WB_in(WB_in), .M_in(M_in),
        .ALU_result_in(ALU_result_in), .ALU_src2_in(ALU_src2_in),
        .ALU_zero_in(ALU_zero_in), .PC_in(PC_in), .REG_dst_in(REG_dst_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .WB_out(WB_out), .mem_rdata_out(mem_rdata_out),
        .ALU_result_out(ALU_result_out), .REG_dst_out(REG_dst_out),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        tick();
        tick();
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wb", 32'(WB_out), 32'd0);
        check("rst_alu", ALU_result_out, 32'd0);
        check("rst_err", 32'(misalign_err), 32'd0);
        #3 rst = 1'b0;
        tick();

        // 1. ALU op passes straight through in one edge
        M_in = 3'b000; WB_in = 2'b10; ALU_result_in = 32'h0000_1234; REG_dst_in = 5'd5;
        #1 check("alu_stall", 32'(stall), 32'd0);
        tick();
        check("alu_wb", 32'(WB_out), 32'h2);
        check("alu_res", ALU_result_out, 32'h0000_1234);
        check("alu_dst", 32'(REG_dst_out), 32'd5);
        check("alu_rdata", mem_rdata_out, 32'd0);
        check("alu_stall2", 32'(stall), 32'd0);

        // 2. Load to 0x40; ack arrives in the third request cycle
        M_in = 3'b010; WB_in = 2'b11; ALU_result_in = 32'h0000_0040; REG_dst_in = 5'd7;
        stall_cnt = 0; req_cnt = 0;
        #1 check("ld_stall_idle", 32'(stall), 32'd1);
        if (stall) stall_cnt++;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("ld_req", 32'(dmem_req), 32'd1);
            check("ld_we", 32'(dmem_we), 32'd0);
            check("ld_addr", dmem_addr, 32'h0000_0040);
            check("ld_bubble", 32'(WB_out), 32'd0);
            check("ld_stall_busy", 32'(stall), 32'd1);
            if (stall) stall_cnt++;
            if (dmem_req) req_cnt++;
        end
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1 check("ld_stall_ack", 32'(stall), 32'd0);
        check("ld_req_ack", 32'(dmem_req), 32'd1);
        if (stall) stall_cnt++;
        if (dmem_req) req_cnt++;
        check("ld_stall_cycles", stall_cnt, 32'd3);
        check("ld_req_cycles", req_cnt, 32'd3);
        tick();
        dmem_ack = 1'b0; M_in = 3'b000; dmem_rdata = 32'd0;
        check("ld_req_done", 32'(dmem_req), 32'd0);
        check("ld_rdata", mem_rdata_out, 32'hDEAD_BEEF);
        check("ld_wb", 32'(WB_out), 32'h3);
        check("ld_res", ALU_result_out, 32'h0000_0040);
        check("ld_dst", 32'(REG_dst_out), 32'd7);

        // 3. Store with immediate ack; read data must not leak into MEM/WB
        M_in = 3'b001; WB_in = 2'b00; ALU_result_in = 32'h0000_0080;
        ALU_src2_in = 32'hA5A5_A5A5; REG_dst_in = 5'd3;
        #1 check("st_stall_idle", 32'(stall), 32'd1);
        tick();
        check("st_req", 32'(dmem_req), 32'd1);
        check("st_we", 32'(dmem_we), 32'd1);
        check("st_wdata", dmem_wdata, 32'hA5A5_A5A5);
        check("st_addr", dmem_addr, 32'h0000_0080);
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
        #1 check("st_stall_ack", 32'(stall), 32'd0);
        tick();
        dmem_ack = 1'b0; M_in = 3'b000;
        check("st_req_done", 32'(dmem_req), 32'd0);
        check("st_rdata", mem_rdata_out, 32'd0);
        check("st_res", ALU_result_out, 32'h0000_0080);

        // 4. Branch resolution is combinational
        M_in = 3'b100; ALU_zero_in = 1'b1; PC_in = 32'h0000_0100;
        #1 check("br_taken", 32'(pc_src), 32'd1);
        check("br_target", branch_target, 32'h0000_0100);
        check("br_stall", 32'(stall), 32'd0);
        ALU_zero_in = 1'b0;
        #1 check("br_not_taken", 32'(pc_src), 32'd0);
        tick();
        M_in = 3'b000;

        // 5. Reset during BUSY aborts the access
        M_in = 3'b010; WB_in = 2'b11; ALU_result_in = 32'h0000_0044; REG_dst_in = 5'd9;
        tick();
        check("ab_req", 32'(dmem_req), 32'd1);
        M_in = 3'b000;
        rst = 1'b1;
        #1 check("ab_req_drop", 32'(dmem_req), 32'd0);
        check("ab_addr", dmem_addr, 32'd0);
        check("ab_wb", 32'(WB_out), 32'd0);
        check("ab_alu", ALU_result_out, 32'd0);
        check("ab_stall", 32'(stall), 32'd0);
        #3 rst = 1'b0;
        tick();
        WB_in = 2'b01; ALU_result_in = 32'h0000_0007; dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
        tick();
        dmem_ack = 1'b0;
        check("ab_ack_ignored_req", 32'(dmem_req), 32'd0);
        check("ab_ack_ignored_rd", mem_rdata_out, 32'd0);
        check("ab_ack_ignored_wb", 32'(WB_out), 32'h1);
        M_in = 3'b010; WB_in = 2'b11; ALU_result_in = 32'h0000_0048; REG_dst_in = 5'd4;
        tick();
        check("ab_ld2_req", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_ack = 1'b0; M_in = 3'b000;
        check("ab_ld2_rdata", mem_rdata_out, 32'hCAFE_F00D);
        check("ab_ld2_wb", 32'(WB_out), 32'h3);

        // 6. Misaligned load to 0x42
        M_in = 3'b010; WB_in = 2'b11; ALU_result_in = 32'h0000_0042; REG_dst_in = 5'd6;
`ifdef DMEM_MISALIGN_CHK_EN
        #1 check("mis_stall", 32'(stall), 32'd0);
        tick();
        M_in = 3'b000;
        check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_wb", 32'(WB_out), 32'd0);
        tick();
        tick();
        check("mis_err_sticky", 32'(misalign_err), 32'd1);
`else
        #1 check("mis_stall", 32'(stall), 32'd1);
        tick();
        M_in = 3'b000;
        check("mis_req", 32'(dmem_req), 32'd1);
        check("mis_addr", dmem_addr, 32'h0000_0042);
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        tick();
        dmem_ack = 1'b0;
        check("mis_rdata", mem_rdata_out, 32'h1234_5678);
        check("mis_err", 32'(misalign_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
